// File: rtl/bitmode_addr_gen_if.sv
// CPU bus and DRAM-stage address signals for the bit-mode address generator.
// The master side drives the CPU bus cycle. The slave side (the generator) returns the DRAM address.
interface bitmode_addr_gen_if;
    logic [15:0] AB;
    logic [7:0]  BD;
    logic        BRWn;
    logic        cpu_valid;
    logic        cycle_end;
    logic        DRAMn;
    logic [14:0] DRBA;
    logic        BITMDn;
    logic        PIXA;

    modport master (
        output AB, BD, BRWn, cpu_valid, cycle_end, DRAMn,
        input  DRBA, BITMDn, PIXA
    );

    modport slave (
        input  AB, BD, BRWn, cpu_valid, cycle_end, DRAMn,
        output DRBA, BITMDn, PIXA
    );
endinterface

// File: rtl/bitmode_addr_gen.sv
// Bit-mode X/Y pointer address generator for the CPU-to-video-DRAM path.
// It decodes CPU bus cycles into DRBA/BITMDn/PIXA and steps the pointers after each bit-mode access.
module bitmode_addr_gen #(
    parameter logic [15:0] BM_ADDR   = 16'h0000,
    parameter logic [15:0] X_ADDR    = 16'h0001,
    parameter logic [15:0] Y_ADDR    = 16'h0002,
    parameter logic [15:0] CTRL_BASE = 16'h9D00
) (
    input  logic              clk,
    input  logic              reset,
    bitmode_addr_gen_if.slave bus,
    output logic [7:0]        bm_x,
    output logic [7:0]        bm_y,
    output logic [3:0]        ctrl
);
    typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_SET_X, OP_SET_Y, OP_SET_CTRL, OP_STEP} op_t;

    state_t      state, state_next;
    op_t         op_dec, op_q;
    logic        capture;
    logic [1:0]  ctrl_sel_q;
    logic [7:0]  data_q;
    logic [15:0] ctrl_off;
    logic        bm_sel;
    logic        unused_dramn;

    // The DRAM window decode is already implied by AB, so DRAMn is not needed here.
    assign unused_dramn = bus.DRAMn;
    assign ctrl_off     = bus.AB - CTRL_BASE;

    always_comb begin
        op_dec = OP_NONE;
        if (bus.AB == BM_ADDR) begin
            op_dec = OP_STEP;
        end else if (!bus.BRWn) begin
            if (bus.AB == X_ADDR) begin
                op_dec = OP_SET_X;
            end else if (bus.AB == Y_ADDR) begin
                op_dec = OP_SET_Y;
            end else if (ctrl_off < 16'd4) begin
                op_dec = OP_SET_CTRL;
            end
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_valid) begin
                    capture    = 1'b1;
                    state_next = bus.cycle_end ? COMMIT : ACTIVE;
                end
            end
            ACTIVE: begin
                if (!bus.cpu_valid) begin
                    state_next = IDLE;
                end else if (bus.cycle_end) begin
                    state_next = COMMIT;
                end
            end
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= OP_NONE;
            data_q     <= 8'h00;
            ctrl_sel_q <= 2'd0;
        end else begin
            state <= state_next;
            if (capture) begin
                op_q       <= op_dec;
                data_q     <= bus.BD;
                ctrl_sel_q <= ctrl_off[1:0];
            end
        end
    end

    // Pointer arithmetic wraps at 8 bits; X and Y never carry into each other.
    always_ff @(posedge clk) begin
        if (reset) begin
            bm_x <= 8'h00;
            bm_y <= 8'h00;
            ctrl <= 4'h0;
        end else if (state == COMMIT) begin
            case (op_q)
                OP_SET_X:    bm_x <= data_q;
                OP_SET_Y:    bm_y <= data_q;
                OP_SET_CTRL: ctrl[ctrl_sel_q] <= data_q[7];
                OP_STEP: begin
                    if (ctrl[0]) bm_x <= ctrl[2] ? bm_x - 8'd1 : bm_x + 8'd1;
                    if (ctrl[1]) bm_y <= ctrl[3] ? bm_y - 8'd1 : bm_y + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign bm_sel     = bus.cpu_valid && (bus.AB == BM_ADDR);
    assign bus.DRBA   = bm_sel ? {bm_y, bm_x[7:1]} : bus.AB[14:0];
    assign bus.PIXA   = bm_x[0];
    assign bus.BITMDn = ~bm_sel;
endmodule

// File: tb/tb_bitmode_addr_gen.sv
// Directed bench for bitmode_addr_gen: a transaction-level pointer model is checked on every
// falling edge, and literal expectations from the hand-worked scenarios are checked as well.
module tb_bitmode_addr_gen;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bm_x, bm_y;
    logic [3:0] ctrl;

    bitmode_addr_gen_if bus ();

    bitmode_addr_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .bm_x  (bm_x),
        .bm_y  (bm_y),
        .ctrl  (ctrl)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    int mx, my;
    bit ax, ay, xdec, ydec;

    logic [14:0] seen_drba;
    logic        seen_pixa, seen_bitmdn;
    int          exp_drba;
    bit          exp_bm;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mx = 0; my = 0;
        ax = 0; ay = 0; xdec = 0; ydec = 0;
    endtask

    // Effect of one completed bus cycle on the programmer-visible state.
    task automatic modelCommit(input logic [15:0] addr, input logic [7:0] data, input logic rw);
        if (addr == 16'h0000) begin
            if (ax) mx = xdec ? (mx + 255) % 256 : (mx + 1) % 256;
            if (ay) my = ydec ? (my + 255) % 256 : (my + 1) % 256;
        end else if (rw == 1'b0) begin
            if (addr == 16'h0001) mx = int'(data);
            else if (addr == 16'h0002) my = int'(data);
            else if (addr == 16'h9D00) ax   = data[7];
            else if (addr == 16'h9D01) ay   = data[7];
            else if (addr == 16'h9D02) xdec = data[7];
            else if (addr == 16'h9D03) ydec = data[7];
        end
    endtask

    // One full CPU bus cycle of nclk clocks; cycle_end marks the last one.
    task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data,
                                 input logic rw, input int nclk);
        bus.AB        = addr;
        bus.BD        = data;
        bus.BRWn      = rw;
        bus.DRAMn     = addr[15];
        bus.cpu_valid = 1'b1;
        for (int i = 0; i < nclk; i++) begin
            bus.cycle_end = (i == nclk - 1);
            @(negedge clk);
            if (i == 0) begin
                seen_drba   = bus.DRBA;
                seen_pixa   = bus.PIXA;
                seen_bitmdn = bus.BITMDn;
            end
            @(posedge clk); #1;
        end
        bus.cpu_valid = 1'b0;
        bus.cycle_end = 1'b0;
        bus.AB        = 16'h8000;
        bus.DRAMn     = 1'b1;
        @(posedge clk); #1;
        modelCommit(addr, data, rw);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            exp_bm   = bus.cpu_valid && (bus.AB == 16'h0000);
            exp_drba = exp_bm ? my * 128 + mx / 2 : int'(bus.AB) % 32768;
            checkOutput("cmp_drba",   16'(bus.DRBA),   16'(exp_drba));
            checkOutput("cmp_bitmdn", 16'(bus.BITMDn), 16'(!exp_bm));
            checkOutput("cmp_pixa",   16'(bus.PIXA),   16'(mx % 2));
            checkOutput("cmp_x",      16'(bm_x),       16'(mx));
            checkOutput("cmp_y",      16'(bm_y),       16'(my));
            checkOutput("cmp_ctrl",   16'(ctrl),       16'({ydec, xdec, ay, ax}));
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        reset         = 1'b1;
        bus.AB        = 16'h8000;
        bus.BD        = 8'h00;
        bus.BRWn      = 1'b1;
        bus.cpu_valid = 1'b0;
        bus.cycle_end = 1'b0;
        bus.DRAMn     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.cpu_valid = 1'b1;
        bus.AB        = 16'h0000;
        bus.DRAMn     = 1'b0;
        @(negedge clk);
        checkOutput("reset_drba",   16'(bus.DRBA),   16'h0000);
        checkOutput("reset_bitmdn", 16'(bus.BITMDn), 16'h0000);
        checkOutput("reset_pixa",   16'(bus.PIXA),   16'h0000);
        checkOutput("reset_x",      16'(bm_x),       16'h0000);
        checkOutput("reset_ctrl",   16'(ctrl),       16'h0000);
        bus.cpu_valid = 1'b0;
        #1;
        checkOutput("reset_bitmdn_idle", 16'(bus.BITMDn), 16'h0001);
        @(posedge clk); #1;
        bus.AB    = 16'h8000;
        bus.DRAMn = 1'b1;
        reset     = 1'b0;
        chk_en    = 1'b1;

        // Pointer writes followed by a bit-mode read.
        applyStimulus(16'h0001, 8'h10, 1'b0, 2);
        applyStimulus(16'h0002, 8'h20, 1'b0, 3);
        checkOutput("t1_x", 16'(bm_x), 16'h0010);
        checkOutput("t1_y", 16'(bm_y), 16'h0020);
        applyStimulus(16'h0000, 8'h00, 1'b1, 2);
        checkOutput("t1_drba",   16'(seen_drba),   16'h1008);
        checkOutput("t1_pixa",   16'(seen_pixa),   16'h0000);
        checkOutput("t1_bitmdn", 16'(seen_bitmdn), 16'h0000);

        // X auto-increment across two bit-mode writes.
        applyStimulus(16'h9D00, 8'h80, 1'b0, 2);
        applyStimulus(16'h9D02, 8'h00, 1'b0, 2);
        applyStimulus(16'h0001, 8'h11, 1'b0, 2);
        applyStimulus(16'h0000, 8'hA5, 1'b0, 2);
        checkOutput("t2_pixa0", 16'(seen_pixa), 16'h0001);
        checkOutput("t2_drba0", 16'(seen_drba), 16'h1008);
        applyStimulus(16'h0000, 8'h5A, 1'b0, 2);
        checkOutput("t2_pixa1", 16'(seen_pixa), 16'h0000);
        checkOutput("t2_drba1", 16'(seen_drba), 16'h1009);
        checkOutput("t2_x",     16'(bm_x),      16'h0013);

        // Both pointers wrap in the same step.
        applyStimulus(16'h9D01, 8'h80, 1'b0, 2);
        applyStimulus(16'h9D02, 8'h80, 1'b0, 2);
        applyStimulus(16'h9D03, 8'h00, 1'b0, 2);
        applyStimulus(16'h0001, 8'h00, 1'b0, 2);
        applyStimulus(16'h0002, 8'hFF, 1'b0, 2);
        applyStimulus(16'h0000, 8'h00, 1'b1, 2);
        checkOutput("t3_x",    16'(bm_x), 16'h00FF);
        checkOutput("t3_y",    16'(bm_y), 16'h0000);
        checkOutput("t3_ctrl", 16'(ctrl), 16'h0007);

        // Non-bit-mode accesses leave the pointers and ctrl alone.
        applyStimulus(16'h4ABC, 8'h00, 1'b1, 2);
        checkOutput("t4_drba",   16'(seen_drba),   16'h4ABC);
        checkOutput("t4_bitmdn", 16'(seen_bitmdn), 16'h0001);
        checkOutput("t4_x",      16'(bm_x),        16'h00FF);
        applyStimulus(16'h9D05, 8'h80, 1'b0, 2);
        checkOutput("t4_ctrl", 16'(ctrl), 16'h0007);
        applyStimulus(16'h0001, 8'h42, 1'b1, 2);
        checkOutput("t4_read_x", 16'(bm_x), 16'h00FF);

        // cpu_valid dropping without cycle_end must not commit.
        bus.AB = 16'h0002; bus.BD = 8'h77; bus.BRWn = 1'b0; bus.DRAMn = 1'b0;
        bus.cpu_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.cpu_valid = 1'b0; bus.AB = 16'h8000; bus.DRAMn = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("drop_y", 16'(bm_y), 16'h0000);

        // Reset in the middle of an X write aborts it.
        bus.AB = 16'h0001; bus.BD = 8'h55; bus.BRWn = 1'b0; bus.DRAMn = 1'b0;
        bus.cpu_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
        bus.cpu_valid = 1'b0; bus.AB = 16'h8000; bus.DRAMn = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        modelReset();
        bus.cycle_end = 1'b1;
        @(posedge clk); #1;
        bus.cycle_end = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("t5_x",    16'(bm_x), 16'h0000);
        checkOutput("t5_ctrl", 16'(ctrl), 16'h0000);

        // Stepping disabled, then single-clock bus cycles.
        applyStimulus(16'h0001, 8'h33, 1'b0, 2);
        applyStimulus(16'h0002, 8'h44, 1'b0, 2);
        applyStimulus(16'h0000, 8'h00, 1'b1, 2);
        applyStimulus(16'h0000, 8'h9C, 1'b0, 1);
        applyStimulus(16'h0000, 8'h00, 1'b1, 3);
        checkOutput("t6_x_const", 16'(bm_x), 16'h0033);
        checkOutput("t6_y_const", 16'(bm_y), 16'h0044);
        applyStimulus(16'h9D00, 8'h80, 1'b0, 1);
        applyStimulus(16'h0000, 8'h00, 1'b1, 1);
        checkOutput("t6_x_single", 16'(bm_x), 16'h0034);
        applyStimulus(16'h9D01, 8'h80, 1'b0, 1);
        applyStimulus(16'h9D03, 8'h80, 1'b0, 1);
        applyStimulus(16'h0000, 8'h00, 1'b0, 2);
        checkOutput("t6_x_step", 16'(bm_x), 16'h0035);
        checkOutput("t6_y_dec",  16'(bm_y), 16'h0043);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
